// File: rtl/fpsu_ret_collect_if.sv
// ---------------------------------------------------------------------------
// fpsu_ret_collect_if
// Bundle of the return-word inputs, drain handshake and status outputs of the
// FP/SIMD retirement collector.
//   uN_ret / uN_ret_en  (N=1..6)  per-lane return word and its valid strobe
//   out0_dat / out1_dat           oldest / second-oldest entry {lane, ret}
//   out_vld / out_rdy             drain handshake (2 entries per cycle max)
//   fflags_o / fflags_clr         sticky IEEE flags and their clear
//   stall_o / ovf_o / count_o     issue stall, sticky overflow, occupancy
// Modports: slave = the collector, master = the producer/consumer side.
// ---------------------------------------------------------------------------
interface fpsu_ret_collect_if #(
  parameter int DEPTH = 32
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [13:0]   u1_ret;
  logic [13:0]   u2_ret;
  logic [13:0]   u3_ret;
  logic [13:0]   u4_ret;
  logic [13:0]   u5_ret;
  logic [13:0]   u6_ret;
  logic          u1_ret_en;
  logic          u2_ret_en;
  logic          u3_ret_en;
  logic          u4_ret_en;
  logic          u5_ret_en;
  logic          u6_ret_en;
  logic [16:0]   out0_dat;
  logic [16:0]   out1_dat;
  logic [1:0]    out_vld;
  logic          out_rdy;
  logic [5:0]    fflags_o;
  logic          fflags_clr;
  logic          stall_o;
  logic          ovf_o;
  logic [CW-1:0] count_o;

  modport slave (
    input  u1_ret, u2_ret, u3_ret, u4_ret, u5_ret, u6_ret,
    input  u1_ret_en, u2_ret_en, u3_ret_en, u4_ret_en, u5_ret_en, u6_ret_en,
    input  out_rdy, fflags_clr,
    output out0_dat, out1_dat, out_vld, fflags_o, stall_o, ovf_o, count_o
  );

  modport master (
    output u1_ret, u2_ret, u3_ret, u4_ret, u5_ret, u6_ret,
    output u1_ret_en, u2_ret_en, u3_ret_en, u4_ret_en, u5_ret_en, u6_ret_en,
    output out_rdy, fflags_clr,
    input  out0_dat, out1_dat, out_vld, fflags_o, stall_o, ovf_o, count_o
  );
endinterface

// File: rtl/fpsu_ret_collect.sv
// ---------------------------------------------------------------------------
// fpsu_ret_collect
// Retirement-status collector behind the three-cluster FP/SIMD unit. Captures
// up to six lane return words per cycle, compacts them in ascending lane order
// into an in-order ring buffer and drains up to two entries per cycle.
// Accumulates sticky IEEE flags of stored entries, flags dropped returns as
// overflow and raises a registered issue stall before the ring can fill.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low; clears all state immediately
//   bus   fpsu_ret_collect_if.slave (return words, drain handshake, status);
//         its DEPTH must match this module's DEPTH
// ---------------------------------------------------------------------------
module fpsu_ret_collect #(
  parameter int DEPTH      = 32,
  parameter int STALL_FREE = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  fpsu_ret_collect_if.slave     bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Free-slot arithmetic is one bit wider than the occupancy so that
  // DEPTH - count + pops never wraps.
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW:0] STALL_W = (CW + 1)'(STALL_FREE);

  logic [16:0]   mem_q [DEPTH];
  logic [16:0]   mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0]    fflags_q, fflags_d;
  logic          stall_q, stall_d;
  logic          ovf_q, ovf_d;

  logic [13:0]   ret_s [6];
  logic [5:0]    en_s;
  logic [1:0]    pops_s;
  logic [CW:0]   free_s;
  logic [2:0]    nwr_s;
  logic [5:0]    new_flags_s;
  logic          drop_s;
  logic [PW-1:0] slot_s;
  logic [PW-1:0] head1_s;

  // Lane vectors indexed 0..5 for lanes u1..u6.
  assign ret_s[0] = bus.u1_ret;
  assign ret_s[1] = bus.u2_ret;
  assign ret_s[2] = bus.u3_ret;
  assign ret_s[3] = bus.u4_ret;
  assign ret_s[4] = bus.u5_ret;
  assign ret_s[5] = bus.u6_ret;
  assign en_s     = {bus.u6_ret_en, bus.u5_ret_en, bus.u4_ret_en,
                     bus.u3_ret_en, bus.u2_ret_en, bus.u1_ret_en};

  // Next-state: pop first, then compact enabled lanes into the freed space.
  always_comb begin
    mem_d       = mem_q;
    nwr_s       = 3'd0;
    new_flags_s = 6'd0;
    drop_s      = 1'b0;
    slot_s      = tail_q;

    // Consumer takes every presented entry; presented = min(count, 2).
    if (bus.out_rdy) begin
      if (count_q >= CW'(2)) begin
        pops_s = 2'd2;
      end else if (count_q == CW'(1)) begin
        pops_s = 2'd1;
      end else begin
        pops_s = 2'd0;
      end
    end else begin
      pops_s = 2'd0;
    end

    free_s = DEPTH_W - {1'b0, count_q} + {{(CW - 1){1'b0}}, pops_s};

    // Lowest-numbered lanes win when space runs out; losers only set overflow.
    for (int i = 0; i < 6; i++) begin
      slot_s = tail_q + PW'(nwr_s);
      if (en_s[i]) begin
        if ({{(CW - 2){1'b0}}, nwr_s} < free_s) begin
          mem_d[slot_s] = {3'(i + 1), ret_s[i]};
          new_flags_s   = new_flags_s | ret_s[i][5:0];
          nwr_s         = nwr_s + 3'd1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        drop_s = drop_s;
      end
    end

    head_d   = head_q + PW'(pops_s);
    tail_d   = tail_q + PW'(nwr_s);
    count_d  = count_q - CW'(pops_s) + CW'(nwr_s);
    stall_d  = (DEPTH_W - {1'b0, count_d}) < STALL_W;
    // Flags written in the clear cycle survive the clear.
    fflags_d = (bus.fflags_clr ? 6'd0 : fflags_q) | new_flags_s;
    ovf_d    = ovf_q | drop_s;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      fflags_q <= 6'd0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  // Ring storage; contents are only observable through count-gated outputs,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head1_s = head_q + PW'(1);

  // Outputs are decoded purely from registered state (no input bypass), and
  // data reads as zero when the corresponding valid bit is low.
  always_comb begin
    bus.out_vld  = {count_q >= CW'(2), count_q != CW'(0)};
    if (count_q != CW'(0)) begin
      bus.out0_dat = mem_q[head_q];
    end else begin
      bus.out0_dat = 17'd0;
    end
    if (count_q >= CW'(2)) begin
      bus.out1_dat = mem_q[head1_s];
    end else begin
      bus.out1_dat = 17'd0;
    end
    bus.fflags_o = fflags_q;
    bus.stall_o  = stall_q;
    bus.ovf_o    = ovf_q;
    bus.count_o  = count_q;
  end
endmodule
